// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the RGB LED arbiter and its PWM generator.
// Channel indices match the bit positions of rgb_pwm and the colour slice layout.
package rgb_led_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  function automatic int color_w(input int pwm_bits);
    return 3 * pwm_bits;
  endfunction

endpackage

// File: rtl/rgb_led_arbiter_pwm_gen.sv
// Three-channel PWM generator: free-running counter, duties latched once per frame
// so colour changes only take effect on frame boundaries.
module rgb_pwm_gen
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3*PWM_BITS-1:0]   i_color,
  output logic [2:0]              o_pwm,
  output logic                    o_frame_strobe
);

  logic [PWM_BITS-1:0] r_cnt;
  logic                w_last;

  assign w_last         = (r_cnt == {PWM_BITS{1'b1}});
  assign o_frame_strobe = w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + 1'b1;
  end

  for (genvar k = CH_B; k <= CH_R; k++) begin : g_ch
    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;

    // Duty reloads on the last count so the next frame starts with the new value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_duty <= '0;
        r_pwm  <= 1'b0;
      end else begin
        if (w_last) r_duty <= i_color[k*PWM_BITS +: PWM_BITS];
        r_pwm <= (r_cnt < r_duty);
      end
    end

    assign o_pwm[k] = r_pwm;
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin owner arbitration for the shared RGB LED with a minimum hold time;
// the owner's colour (or IDLE_COLOR) drives the PWM generator each frame.
module rgb_led_arbiter
  import rgb_led_pkg::*;
#(
  parameter int                      NUM_REQ     = 3,
  parameter int                      PWM_BITS    = 8,
  parameter int                      HOLD_CYCLES = 1200000,
  parameter logic [3*PWM_BITS-1:0]   IDLE_COLOR  = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*3*PWM_BITS-1:0]     color,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              busy,
  output logic [2:0]                        rgb_pwm,
  output logic                              frame_strobe
);

  localparam int              CW        = color_w(PWM_BITS);
  localparam int              OW        = $clog2(NUM_REQ);
  localparam int              HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [OW:0]     NREQ_W    = (OW+1)'(NUM_REQ);
  localparam logic [OW-1:0]   LAST_RST  = OW'(NUM_REQ - 1);

  arb_state_e           r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [OW-1:0]        r_last,  w_last_nxt;
  logic [HW-1:0]        r_hold,  w_hold_nxt;

  logic [NUM_REQ-1:0]   w_mask;
  logic                 w_win_vld;
  logic [OW-1:0]        w_win_idx;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic                 w_owner_req;
  logic                 w_hold_done;
  logic [CW-1:0]        w_act_color;

  // The current owner is excluded, so the search only ever finds a different requester.
  assign w_mask      = req & ~r_grant;
  assign w_owner_req = |(req & r_grant);
  assign w_hold_done = (r_hold == HOLD_MAX);
  assign w_win_oh    = NUM_REQ'(1) << w_win_idx;

  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      logic [OW:0] t;
      t = {1'b0, r_last} + (OW+1)'(i);
      if (t >= NREQ_W) t = t - NREQ_W;
      if (!w_win_vld && w_mask[t[OW-1:0]]) begin
        w_win_vld = 1'b1;
        w_win_idx = t[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LAST_RST;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = OWNED;
          w_grant_nxt = w_win_oh;
          w_last_nxt  = w_win_idx;
          w_hold_nxt  = '0;
        end
      end
      OWNED: begin
        // A drop releases immediately; expiry only hands over when someone is waiting.
        if (!w_owner_req || (w_hold_done && w_win_vld)) begin
          w_hold_nxt = '0;
          if (w_win_vld) begin
            w_grant_nxt = w_win_oh;
            w_last_nxt  = w_win_idx;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
          end
        end else if (!w_hold_done) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_act_color = IDLE_COLOR;
    for (int i = 0; i < NUM_REQ; i++)
      if (r_grant[i]) w_act_color = color[i*CW +: CW];
  end

  assign grant = r_grant;
  assign busy  = |r_grant;

  rgb_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk            (clk),
    .rst            (rst),
    .i_color        (w_act_color),
    .o_pwm          (rgb_pwm),
    .o_frame_strobe (frame_strobe)
  );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter: cycle model feeds a scoreboard, plus directed
// latency, hold-time, frame-latch and async-reset checks.
module tb_rgb_led_arbiter;

  localparam int NR = 3;
  localparam int PB = 4;
  localparam int HC = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [35:0]   color;
  logic [NR-1:0] grant;
  logic          busy;
  logic [2:0]    rgb_pwm;
  logic          frame_strobe;

  int n_run  = 0;
  int n_fail = 0;

  rgb_led_arbiter #(
    .NUM_REQ     (NR),
    .PWM_BITS    (PB),
    .HOLD_CYCLES (HC),
    .IDLE_COLOR  (12'h000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .color        (color),
    .grant        (grant),
    .busy         (busy),
    .rgb_pwm      (rgb_pwm),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0] g;
    logic       b;
    logic [2:0] p;
    logic       s;
  } exp_t;

  exp_t sb[$];
  exp_t e_q;

  int         m_cnt;
  int         m_duty[3];
  logic [2:0] m_grant;
  logic [2:0] m_pwm;
  int         m_last;
  int         m_hold;

  function automatic int rr(input logic [2:0] mask, input int last);
    for (int i = 1; i <= NR; i++) begin
      int j;
      j = (last + i) % NR;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  // Reference model, stepped on the same edge as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      for (int k = 0; k < 3; k++) m_duty[k] = 0;
      m_grant = '0;
      m_pwm   = '0;
      m_last  = NR - 1;
      m_hold  = 0;
      sb.delete();
    end else begin
      int         w;
      logic [11:0] act;
      for (int k = 0; k < 3; k++) m_pwm[k] = (m_cnt < m_duty[k]);
      if (m_cnt == 15) begin
        act = (m_grant != 0) ? 12'((color >> (m_last * 12)) & 36'hFFF) : 12'h000;
        for (int k = 0; k < 3; k++) m_duty[k] = (act >> (k * 4)) & 15;
      end
      m_cnt = (m_cnt + 1) % 16;
      if (m_grant == 0) begin
        w = rr(req, m_last);
        if (w >= 0) begin m_grant = 3'(1 << w); m_last = w; m_hold = 0; end
      end else if (!req[m_last]) begin
        w = rr(req & ~m_grant, m_last);
        m_hold = 0;
        if (w >= 0) begin m_grant = 3'(1 << w); m_last = w; end
        else m_grant = '0;
      end else if (m_hold == HC && rr(req & ~m_grant, m_last) >= 0) begin
        w = rr(req & ~m_grant, m_last);
        m_grant = 3'(1 << w); m_last = w; m_hold = 0;
      end else if (m_hold < HC) begin
        m_hold++;
      end
      sb.push_back('{g: m_grant, b: (m_grant != 0), p: m_pwm, s: (m_cnt == 15)});
    end
  end

  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      e_q = sb.pop_front();
      chk("sb_grant",  32'(grant),        32'(e_q.g));
      chk("sb_busy",   32'(busy),         32'(e_q.b));
      chk("sb_pwm",    32'(rgb_pwm),      32'(e_q.p));
      chk("sb_strobe", 32'(frame_strobe), 32'(e_q.s));
    end
  end

  task automatic wait_strobe();
    int t = 0;
    while (!frame_strobe && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) chk("strobe_timeout", 32'(frame_strobe), 32'd1);
  endtask

  // Counts high cycles per channel across one frame starting at the next strobe;
  // optionally rewrites colour 0 at count 7 of that frame.
  task automatic count_frame(input bit do_chg, input logic [11:0] newc,
                             output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    wait_strobe();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (do_chg && i == 7) color[11:0] = newc;
      r += int'(rgb_pwm[2]);
      g += int'(rgb_pwm[1]);
      b += int'(rgb_pwm[0]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_len(input logic [2:0] g, output int n);
    n = 0;
    while (grant == g && n < 100) begin @(negedge clk); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout run=%0d", n_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, b, n;
    rst   = 1'b1;
    req   = '0;
    color = '0;
    #1;
    chk("rst_grant",  32'(grant),        32'd0);
    chk("rst_busy",   32'(busy),         32'd0);
    chk("rst_pwm",    32'(rgb_pwm),      32'd0);
    chk("rst_strobe", 32'(frame_strobe), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle: strobe period and dark output for three frames
    for (int f = 0; f < 3; f++) begin
      wait_strobe();
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_strobe && n < 64);
      chk("strobe_period", 32'(n), 32'd16);
      chk("idle_grant",    32'(grant), 32'd0);
    end
    count_frame(1'b0, 12'h0, r, g, b);
    chk("idle_rgb", 32'(r + g + b), 32'd0);

    // Single requester: one-cycle grant latency, then duties R4 G15 B0
    color[11:0] = 12'h4F0;
    req = 3'b001;
    @(negedge clk);
    chk("lat_grant", 32'(grant), 32'b001);
    chk("lat_busy",  32'(busy),  32'd1);
    count_frame(1'b0, 12'h0, r, g, b);
    chk("duty_r", 32'(r), 32'd4);
    chk("duty_g", 32'(g), 32'd15);
    chk("duty_b", 32'(b), 32'd0);

    // Hold time: 0 and 2 both request, ownership alternates every HC+1 cycles
    do_reset();
    color[35:24] = 12'hFFF;
    req = 3'b101;
    @(negedge clk);
    chk("rr_first", 32'(grant), 32'b001);
    run_len(3'b001, n);
    chk("hold_len0", 32'(n), 32'(HC + 1));
    chk("preempt_2", 32'(grant), 32'b100);
    run_len(3'b100, n);
    chk("hold_len2", 32'(n), 32'(HC + 1));
    chk("preempt_0", 32'(grant), 32'b001);

    // Owner drop at hold 5 hands over immediately, then release to idle
    repeat (5) @(negedge clk);
    req = 3'b100;
    @(negedge clk);
    chk("drop_hand", 32'(grant), 32'b100);
    req = 3'b000;
    @(negedge clk);
    chk("drop_idle", 32'(grant), 32'd0);
    chk("drop_busy", 32'(busy),  32'd0);
    count_frame(1'b0, 12'h0, r, g, b);
    chk("idle_color", 32'(r + g + b), 32'd0);

    // Mid-frame colour change only takes effect on the following frame
    color[11:0] = 12'h200;
    req = 3'b001;
    @(negedge clk);
    chk("mf_grant", 32'(grant), 32'b001);
    count_frame(1'b1, 12'hA00, r, g, b);
    chk("mf_cur_r",  32'(r), 32'd2);
    count_frame(1'b0, 12'h0, r, g, b);
    chk("mf_next_r", 32'(r), 32'd10);

    // Async reset mid-frame while owned and red is high
    n = 0;
    while (!rgb_pwm[2] && n < 64) begin @(negedge clk); n++; end
    chk("pre_rst_pwm", 32'(rgb_pwm[2]), 32'd1);
    #2;
    rst = 1'b1;
    req = 3'b010;
    #1;
    chk("arst_grant", 32'(grant),   32'd0);
    chk("arst_busy",  32'(busy),    32'd0);
    chk("arst_pwm",   32'(rgb_pwm), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", 32'(grant), 32'b010);
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
